// File: rtl/cntr_pkg.sv
// Shared definitions for the synchronous down counter: FSM state encoding
// and legal counter width range.
package cntr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cntr_state_e;

    localparam int CNTR_WIDTH_MIN = 2;
    localparam int CNTR_WIDTH_MAX = 16;
    localparam int CNTR_WIDTH_DEF = 4;

endpackage : cntr_pkg

// File: rtl/sync_down_cntr_if.sv
// Control/status bundle of the down counter; the sequencer side is master,
// the counter itself is slave.
interface sync_down_cntr_if
    import cntr_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH_DEF
);
    logic             cnt_en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             reload_en;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output cnt_en, load, load_val, reload_en,
        input  count, tc, busy, done
    );

    modport slave (
        input  cnt_en, load, load_val, reload_en,
        output count, tc, busy, done
    );

endinterface : sync_down_cntr_if

// File: rtl/sync_t_ff_ld.sv
// Single counter bit: T flip-flop with synchronous parallel load (load wins
// over toggle) and asynchronous active-low reset.
module sync_t_ff_ld (
    input  logic clk,
    input  logic rstn,
    input  logic ld,
    input  logic d,
    input  logic T,
    output logic Q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            Q <= 1'b0;
        end else if (ld) begin
            Q <= d;
        end else if (T) begin
            Q <= ~Q;
        end
    end

endmodule : sync_t_ff_ld

// File: rtl/sync_down_cntr.sv
// Synchronous loadable down counter built from toggle flops with a borrow
// chain, plus a one-shot / auto-reload control FSM and a registered tc pulse.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | after reset; count holds, cnt_en ignored, waits for load
//   RUN     | decrementing on cnt_en; terminal step reloads or goes DONE
//   DONE    | one-shot finished (or zero loaded); count holds at 0
module sync_down_cntr
    import cntr_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    sync_down_cntr_if.slave  bus
);

    if (WIDTH < CNTR_WIDTH_MIN || WIDTH > CNTR_WIDTH_MAX) begin : g_width_chk
        $error("sync_down_cntr: WIDTH out of legal range");
    end

    cntr_state_e      state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] count_w;
    logic [WIDTH-1:0] tog_w;
    logic [WIDTH-1:0] ld_val;
    logic             ld;
    logic             dec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        ld       = 1'b0;
        ld_val   = bus.load_val;
        dec      = 1'b0;

        if (bus.load) begin
            ld       = 1'b1;
            ld_val   = bus.load_val;
            reload_d = bus.load_val;
            state_d  = (bus.load_val != '0) ? ST_RUN : ST_DONE;
        end else if (state_q == ST_RUN && bus.cnt_en) begin
            if (count_w == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (bus.reload_en) begin
                    ld     = 1'b1;
                    ld_val = reload_q;
                end else begin
                    dec     = 1'b1;
                    state_d = ST_DONE;
                end
            end else if (count_w != '0) begin
                // The zero guard keeps the counter from ever wrapping to all-ones.
                dec = 1'b1;
            end
        end
    end

    // Borrow chain: a bit flips when every lower bit is zero.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign tog_w[i] = dec;
        end else begin : g_upper
            assign tog_w[i] = dec & (count_w[i-1:0] == '0);
        end

        sync_t_ff_ld u_tff (
            .clk  (clk),
            .rstn (rstn),
            .ld   (ld),
            .d    (ld_val[i]),
            .T    (tog_w[i]),
            .Q    (count_w[i])
        );
    end

    assign bus.count = count_w;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);

endmodule : sync_down_cntr

// File: tb/tb_sync_down_cntr.sv
// Directed bench for sync_down_cntr: a table of per-cycle vectors followed by
// hand-written reset sequences.
module tb_sync_down_cntr;

    localparam int W = 4;

    typedef struct {
        string      name;
        logic       load;
        logic [W-1:0] load_val;
        logic       cnt_en;
        logic       reload_en;
        logic [W-1:0] exp_count;
        logic       exp_tc;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_bad;
    vec_t vecs[$];

    sync_down_cntr_if #(.WIDTH(W)) bus ();

    sync_down_cntr #(.WIDTH(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic ld, logic [W-1:0] lv, logic ce, logic re,
                                logic [W-1:0] ec, logic et, logic eb, logic ed);
        vec_t v;
        v.name = nm; v.load = ld; v.load_val = lv; v.cnt_en = ce; v.reload_en = re;
        v.exp_count = ec; v.exp_tc = et; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    task automatic chk(string nm, logic [W-1:0] ec, logic et, logic eb, logic ed);
        n_vec++;
        if (bus.count !== ec || bus.tc !== et || bus.busy !== eb || bus.done !== ed) begin
            n_bad++;
            $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
                     nm, bus.count, bus.tc, bus.busy, bus.done, ec, et, eb, ed);
        end
    endtask

    task automatic drive(logic ld, logic [W-1:0] lv, logic ce, logic re);
        bus.load      = ld;
        bus.load_val  = lv;
        bus.cnt_en    = ce;
        bus.reload_en = re;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked there too.
    task automatic step(logic ld, logic [W-1:0] lv, logic ce, logic re);
        drive(ld, lv, ce, re);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn  = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);

        // one-shot from 5
        vecs.push_back(mk("os_load5", 1, 4'd5, 1, 0, 4'd5, 0, 1, 0));
        vecs.push_back(mk("os_4",     0, 4'd0, 1, 0, 4'd4, 0, 1, 0));
        vecs.push_back(mk("os_3",     0, 4'd0, 1, 0, 4'd3, 0, 1, 0));
        vecs.push_back(mk("os_2",     0, 4'd0, 1, 0, 4'd2, 0, 1, 0));
        vecs.push_back(mk("os_1",     0, 4'd0, 1, 0, 4'd1, 0, 1, 0));
        vecs.push_back(mk("os_tc",    0, 4'd0, 1, 0, 4'd0, 1, 0, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("os_hold0", 0, 4'd0, 1, 0, 4'd0, 0, 0, 1));
        // auto-reload period 3
        vecs.push_back(mk("ar_load3", 1, 4'd3, 1, 1, 4'd3, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk("ar_2",   0, 4'd0, 1, 1, 4'd2, 0, 1, 0));
            vecs.push_back(mk("ar_1",   0, 4'd0, 1, 1, 4'd1, 0, 1, 0));
            vecs.push_back(mk("ar_rl3", 0, 4'd0, 1, 1, 4'd3, 1, 1, 0));
        end
        // gated enable from 4
        vecs.push_back(mk("ge_load4", 1, 4'd4, 0, 0, 4'd4, 0, 1, 0));
        vecs.push_back(mk("ge_e1",    0, 4'd0, 1, 0, 4'd3, 0, 1, 0));
        vecs.push_back(mk("ge_e0a",   0, 4'd0, 0, 0, 4'd3, 0, 1, 0));
        vecs.push_back(mk("ge_e0b",   0, 4'd0, 0, 0, 4'd3, 0, 1, 0));
        vecs.push_back(mk("ge_e1b",   0, 4'd0, 1, 0, 4'd2, 0, 1, 0));
        vecs.push_back(mk("ge_e1c",   0, 4'd0, 1, 0, 4'd1, 0, 1, 0));
        vecs.push_back(mk("ge_e0c",   0, 4'd0, 0, 0, 4'd1, 0, 1, 0));
        vecs.push_back(mk("ge_tc",    0, 4'd0, 1, 0, 4'd0, 1, 0, 1));
        // load beats terminal decrement
        vecs.push_back(mk("lt_load2", 1, 4'd2, 0, 0, 4'd2, 0, 1, 0));
        vecs.push_back(mk("lt_1",     0, 4'd0, 1, 0, 4'd1, 0, 1, 0));
        vecs.push_back(mk("lt_load9", 1, 4'd9, 1, 0, 4'd9, 0, 1, 0));
        vecs.push_back(mk("lt_8",     0, 4'd0, 1, 0, 4'd8, 0, 1, 0));
        // reload_en only matters at the terminal step
        vecs.push_back(mk("re_load2", 1, 4'd2, 0, 1, 4'd2, 0, 1, 0));
        vecs.push_back(mk("re_1",     0, 4'd0, 1, 1, 4'd1, 0, 1, 0));
        vecs.push_back(mk("re_tc",    0, 4'd0, 1, 0, 4'd0, 1, 0, 1));
        vecs.push_back(mk("re_hold",  0, 4'd0, 1, 1, 4'd0, 0, 0, 1));
        // load of zero, no wrap
        vecs.push_back(mk("z_load0",  1, 4'd0, 1, 1, 4'd0, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("z_nowrap", 0, 4'd0, 1, 1, 4'd0, 0, 0, 1));
        // top-bit borrow across all bits
        vecs.push_back(mk("b_load8",  1, 4'd8, 0, 0, 4'd8, 0, 1, 0));
        vecs.push_back(mk("b_7",      0, 4'd0, 1, 0, 4'd7, 0, 1, 0));

        #2;
        chk("reset_state", 4'd0, 0, 0, 0);
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_release", 4'd0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].load, vecs[i].load_val, vecs[i].cnt_en, vecs[i].reload_en);
            chk(vecs[i].name, vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // async reset mid-count at 6
        step(1, 4'd8, 0, 0);
        step(0, 4'd0, 1, 0);
        step(0, 4'd0, 1, 0);
        chk("pre_rst_6", 4'd6, 0, 1, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_midcount", 4'd0, 0, 0, 0);
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 4'd0, 1, 1);
            chk("idle_ignores_en", 4'd0, 0, 0, 0);
        end

        // async reset while tc is high
        step(1, 4'd1, 0, 0);
        chk("tcr_load1", 4'd1, 0, 1, 0);
        step(0, 4'd0, 1, 0);
        chk("tcr_tc_hi", 4'd0, 1, 0, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("tcr_rst_clears_tc", 4'd0, 0, 0, 0);
        #2;
        rstn = 1'b1;
        step(0, 4'd0, 1, 0);
        chk("tcr_idle", 4'd0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_sync_down_cntr
